// File: rtl/scan_decoder_pkg.sv
// Shared definitions for the scan decoder: state encoding and a generic one-hot helper.
// The helper returns a fixed-width vector; callers keep the low 2**n positions.
package scan_dec_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DIRECT = 2'd1;
  localparam logic [1:0] ST_SCAN   = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_DIRECT = ST_DIRECT,
    S_SCAN   = ST_SCAN
  } state_e;

  // Largest select width the helper supports.
  localparam int MAX_N    = 6;
  localparam int ONEHOT_W = 2 ** MAX_N;

  function automatic logic [0:ONEHOT_W-1] onehot(input logic [MAX_N-1:0] idx, input int n);
    logic [0:ONEHOT_W-1] r;
    r = '0;
    for (int i = 0; i < ONEHOT_W; i++) begin
      if (i < (1 << n) && idx == MAX_N'(i)) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/scan_decoder_if.sv
// Control/status bundle of the scan decoder.
// load is accepted on a rising clock edge when load && ready; there is no backpressure on outputs.
interface scan_decoder_if #(
  parameter int N = 4
);
  logic              En;
  logic              Mode;
  logic [N-1:0]      W;
  logic [N:0]        Len;
  logic              load;
  logic              ready;
  logic [0:2**N-1]   Y;
  logic [N-1:0]      idx;
  logic              wrap;
  logic              done;
  logic [1:0]        dbg_state;

  modport master (
    output En, Mode, W, Len, load,
    input  ready, Y, idx, wrap, done, dbg_state
  );

  modport slave (
    input  En, Mode, W, Len, load,
    output ready, Y, idx, wrap, done, dbg_state
  );
endinterface

// File: rtl/scan_decoder_onehot_dec.sv
// Combinational N-to-2**N one-hot decoder with enable, built on the package helper.
module onehot_dec
  import scan_dec_pkg::*;
#(
  parameter int N = 4
) (
  input  logic            en,
  input  logic [N-1:0]    sel,
  output logic [0:2**N-1] y
);
  localparam int OUTS = 2 ** N;

  logic [0:ONEHOT_W-1] full;
  logic                spare_clear;

  assign full = onehot(MAX_N'(sel), N);

  // Positions above OUTS can never be set for an N-bit select; folding them in
  // keeps every helper bit observed and costs nothing after optimisation.
  if (OUTS < ONEHOT_W) begin : g_spare
    assign spare_clear = ~|full[OUTS:ONEHOT_W-1];
  end else begin : g_full
    assign spare_clear = 1'b1;
  end

  assign y = (en && spare_clear) ? full[0:OUTS-1] : '0;

endmodule

// File: rtl/scan_decoder.sv
// Registered one-hot decoder with DIRECT decode and an auto-stepping SCAN burst mode.
// FSM, hold counter and remaining-step counter live here; the decoder feeds the Y register.
module scan_decoder
  import scan_dec_pkg::*;
#(
  parameter int N    = 4,
  parameter int HOLD = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  scan_decoder_if.slave  bus
);
  localparam int              OUTS      = 2 ** N;
  localparam int              HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD - 1);
  localparam logic [N:0]      REM_ONE   = 1;

  state_e          state_q, state_d;
  logic [0:OUTS-1] y_q, y_d;
  logic [N-1:0]    idx_q, idx_d;
  logic [N:0]      rem_q, rem_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic            wrap_q, wrap_d;
  logic            done_q, done_d;

  logic            dec_en;
  logic [N-1:0]    dec_sel;
  logic            step_end;
  logic [N-1:0]    idx_nxt;

  onehot_dec #(.N(N)) u_dec (
    .en  (dec_en),
    .sel (dec_sel),
    .y   (y_d)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rem_d    = rem_q;
    hold_d   = hold_q;
    wrap_d   = 1'b0;
    done_d   = 1'b0;
    dec_en   = 1'b0;
    dec_sel  = idx_q;
    step_end = (hold_q == HOLD_LAST);
    idx_nxt  = idx_q + 1'b1;

    if (!bus.En) begin
      state_d = S_IDLE;
      idx_d   = '0;
      rem_d   = '0;
      hold_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (!bus.Mode) begin
            state_d = S_DIRECT;
            idx_d   = bus.W;
            dec_sel = bus.W;
            dec_en  = 1'b1;
          end else if (bus.load) begin
            state_d = S_SCAN;
            idx_d   = bus.W;
            dec_sel = bus.W;
            dec_en  = 1'b1;
            rem_d   = bus.Len;
            hold_d  = '0;
          end else begin
            idx_d = '0;
          end
        end

        S_DIRECT: begin
          if (bus.Mode) begin
            state_d = S_IDLE;
            idx_d   = '0;
          end else begin
            idx_d   = bus.W;
            dec_sel = bus.W;
            dec_en  = 1'b1;
          end
        end

        S_SCAN: begin
          if (!step_end) begin
            hold_d = hold_q + 1'b1;
            dec_en = 1'b1;
          end else begin
            hold_d = '0;
            // rem of zero marks a continuous scan and is never decremented.
            if (rem_q == REM_ONE) begin
              state_d = S_IDLE;
              idx_d   = '0;
              rem_d   = '0;
              done_d  = 1'b1;
            end else begin
              idx_d   = idx_nxt;
              dec_sel = idx_nxt;
              dec_en  = 1'b1;
              wrap_d  = &idx_q;
              if (rem_q != '0) rem_d = rem_q - 1'b1;
            end
          end
        end

        default: begin
          state_d = S_IDLE;
          idx_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      y_q     <= '0;
      idx_q   <= '0;
      rem_q   <= '0;
      hold_q  <= '0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      hold_q  <= hold_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
    end
  end

  assign bus.Y         = y_q;
  assign bus.idx       = idx_q;
  assign bus.wrap      = wrap_q;
  assign bus.done      = done_q;
  assign bus.ready     = (state_q != S_SCAN);
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Bench for scan_decoder: instance a (HOLD=2) and instance b (HOLD=1), N=4,
// directed steps with randomized fields, outputs compared against an arithmetic burst model.
module tb_scan_decoder;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  scan_decoder_if #(.N(4)) a_if ();
  scan_decoder_if #(.N(4)) b_if ();

  scan_decoder #(.N(4), .HOLD(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if.slave));
  scan_decoder #(.N(4), .HOLD(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if.slave));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic drv(input int s, input bit en, input bit mode, input int w, input int len, input bit ld);
    if (s == 0) begin
      a_if.En = en; a_if.Mode = mode; a_if.W = 4'(w); a_if.Len = 5'(len); a_if.load = ld;
    end else begin
      b_if.En = en; b_if.Mode = mode; b_if.W = 4'(w); b_if.Len = 5'(len); b_if.load = ld;
    end
  endtask

  task automatic sample(input int s, output logic [0:15] y, output logic [3:0] ix,
                        output logic wr, output logic dn, output logic rd);
    if (s == 0) begin
      y = a_if.Y; ix = a_if.idx; wr = a_if.wrap; dn = a_if.done; rd = a_if.ready;
    end else begin
      y = b_if.Y; ix = b_if.idx; wr = b_if.wrap; dn = b_if.done; rd = b_if.ready;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [0:15] hot(input int i);
    logic [0:15] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Expected outputs t cycles after the load edge of a burst (len 0 = endless).
  function automatic void scan_model(input int t, input int w, input int len, input int hold,
                                     output logic [0:15] y, output int ix,
                                     output bit wr, output bit dn, output bit rd);
    int k;
    if (len != 0 && t >= len * hold) begin
      y = '0; ix = 0; wr = 1'b0; dn = (t == len * hold); rd = 1'b1;
    end else begin
      k  = t / hold;
      ix = (w + k) % 16;
      y  = hot(ix);
      wr = (t % hold == 0) && (k > 0) && (ix == 0);
      dn = 1'b0;
      rd = 1'b0;
    end
  endfunction

  task automatic run_scan(input int s, input int w, input int len, input int hold,
                          input int ncyc, input string nm);
    int          total;
    logic [0:15] ey, oy;
    int          eix;
    bit          ew, ed, er;
    logic [3:0]  oix;
    logic        ow, od, orr;
    total = (len == 0) ? ncyc + 1 : len * hold;
    drv(s, 1'b1, 1'b1, w, len, 1'b0);
    @(negedge clk);
    sample(s, oy, oix, ow, od, orr);
    chk($sformatf("%s.pre_ready", nm), 32'(orr), 32'd1);
    drv(s, 1'b1, 1'b1, w, len, 1'b1);
    @(negedge clk);
    for (int t = 0; t < ncyc; t++) begin
      scan_model(t, w, len, hold, ey, eix, ew, ed, er);
      sample(s, oy, oix, ow, od, orr);
      chk($sformatf("%s.t%0d.y", nm, t), 32'(oy), 32'(ey));
      chk($sformatf("%s.t%0d.idx", nm, t), 32'(oix), 32'(eix));
      chk($sformatf("%s.t%0d.wrap", nm, t), 32'(ow), 32'(ew));
      chk($sformatf("%s.t%0d.done", nm, t), 32'(od), 32'(ed));
      chk($sformatf("%s.t%0d.ready", nm, t), 32'(orr), 32'(er));
      if (t < total)
        drv(s, 1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      else
        drv(s, 1'b1, 1'b1, w, len, 1'b0);
      @(negedge clk);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [0:15] oy;
    logic [3:0]  oix;
    logic        ow, od, orr;
    int          w, len;

    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drv(0, 1'b0, 1'b0, 0, 0, 1'b0);
    drv(1, 1'b0, 1'b0, 0, 0, 1'b0);
    repeat (2) @(negedge clk);

    sample(0, oy, oix, ow, od, orr);
    chk("reset.y", 32'(oy), 32'd0);
    chk("reset.idx", 32'(oix), 32'd0);
    chk("reset.wrap", 32'(ow), 32'd0);
    chk("reset.done", 32'(od), 32'd0);
    chk("reset.ready", 32'(orr), 32'd1);
    rst_n = 1'b1;

    // DIRECT sweep, then random DIRECT indices
    for (int i = 0; i < 16; i++) begin
      drv(0, 1'b1, 1'b0, i, 0, 1'b0);
      @(negedge clk);
      sample(0, oy, oix, ow, od, orr);
      chk($sformatf("direct.w%0d.y", i), 32'(oy), 32'(hot(i)));
      chk($sformatf("direct.w%0d.idx", i), 32'(oix), 32'(i));
    end
    for (int i = 0; i < 12; i++) begin
      w = int'($urandom_range(0, 15));
      drv(0, 1'b1, 1'b0, w, int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      @(negedge clk);
      sample(0, oy, oix, ow, od, orr);
      chk($sformatf("direct_rand%0d.y", i), 32'(oy), 32'(hot(w)));
      chk($sformatf("direct_rand%0d.ready", i), 32'(orr), 32'd1);
    end

    // enable low, then async reset in DIRECT
    drv(0, 1'b0, 1'b0, 5, 0, 1'b0);
    @(negedge clk);
    sample(0, oy, oix, ow, od, orr);
    chk("en_low.y", 32'(oy), 32'd0);
    chk("en_low.idx", 32'(oix), 32'd0);
    drv(0, 1'b1, 1'b0, 5, 0, 1'b0);
    @(negedge clk);
    sample(0, oy, oix, ow, od, orr);
    chk("en_high.y", 32'(oy), 32'(hot(5)));
    #2 rst_n = 1'b0;
    #1;
    sample(0, oy, oix, ow, od, orr);
    chk("async_rst.y", 32'(oy), 32'd0);
    chk("async_rst.idx", 32'(oix), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // finite wrapping burst
    run_scan(0, 14, 4, 2, 10, "scan_fin");

    // continuous scan with stray loads, then abort
    run_scan(0, 0, 0, 2, 70, "scan_cont");
    drv(0, 1'b0, 1'b1, 0, 0, 1'b0);
    @(negedge clk);
    sample(0, oy, oix, ow, od, orr);
    chk("cont_stop.y", 32'(oy), 32'd0);
    chk("cont_stop.ready", 32'(orr), 32'd1);

    // abort in the third step of a Len=8 burst, then a fresh load
    w = int'($urandom_range(0, 15));
    run_scan(0, w, 8, 2, 5, "abort");
    drv(0, 1'b0, 1'b1, w, 8, 1'b0);
    @(negedge clk);
    sample(0, oy, oix, ow, od, orr);
    chk("abort.y", 32'(oy), 32'd0);
    chk("abort.idx", 32'(oix), 32'd0);
    chk("abort.done", 32'(od), 32'd0);
    chk("abort.ready", 32'(orr), 32'd1);
    @(negedge clk);
    sample(0, oy, oix, ow, od, orr);
    chk("abort.done_late", 32'(od), 32'd0);
    w   = int'($urandom_range(0, 15));
    len = int'($urandom_range(1, 20));
    run_scan(0, w, len, 2, len * 2 + 2, "restart");

    // random finite bursts, including Len > 16
    for (int r = 0; r < 3; r++) begin
      w   = int'($urandom_range(0, 15));
      len = int'($urandom_range(1, 24));
      run_scan(0, w, len, 2, len * 2 + 2, $sformatf("rand%0d", r));
    end

    // HOLD=1 full walk
    run_scan(1, 0, 16, 1, 18, "hold1");
    w   = int'($urandom_range(0, 15));
    len = int'($urandom_range(1, 31));
    run_scan(1, w, len, 1, len + 2, "hold1_rand");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
